fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding and interlock unit for the pipeline's decode stage. It handles any number of ID read ports and any number of bypass stages, and adds a register scoreboard for a variable-latency multi-cycle unit (MUL/DIV). For each read port it selects the newest producer, stalls ID on load-use, pending multi-cycle and WAW hazards, and counts stall cycles.

## Interface
- NRP, 3 — number of ID source-register read ports
- NSRC, 3 — pipeline bypass stages; index 0 = youngest (EX), NSRC-1 = oldest (WB)
- NREG, 32 — architectural registers; register 0 is hardwired zero
- RW, $clog2(NREG) — register-index width
- SEL_W, $clog2(NSRC+2) — select width per port
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_rs  in  NRP*RW  source register per port, port p at [p*RW +: RW]
- id_rs_used  in  NRP  port p actually reads its register
- id_rd  in  RW  ID destination register
- id_we  in  1  ID instruction writes id_rd
- id_is_mc  in  1  ID instruction goes to the multi-cycle unit
- id_fire  in  1  ID instruction advances to EX this cycle
- stg_rd  in  NSRC*RW  destination register per stage
- stg_we  in  NSRC  stage writes its rd
- stg_rdy  in  NSRC  stage result is already computed (0 for a load in EX)
- mc_done  in  1  multi-cycle unit writes back this cycle
- mc_rd  in  RW  multi-cycle writeback register
- fwd_sel  out  NRP*SEL_W  per-port source: 0 regfile, k+1 stage k, NSRC+1 multi-cycle result
- stall  out  1  hold PC/IF/ID and bubble EX
- mc_busy  out  1  multi-cycle unit occupied
- pend  out  NREG  scoreboard bitmap
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- **Port match (per port p):**
  - Consider only ports with id_rs_used[p]=1 and id_rs≠0.
  - Scan stages 0..NSRC-1 in that order. The first stage k with stg_we[k] and stg_rd[k]==id_rs is selected: fwd_sel=k+1.
  - If no stage matches and mc_done && mc_rd==id_rs, then fwd_sel=NSRC+1.
  - Otherwise fwd_sel=0.
- **Hazards.** stall=1 if any used port has one of:
  - (a) its selected stage k has stg_rdy[k]=0;
  - (b) pend[id_rs]=1 and not (mc_done && mc_rd==id_rs).
- **Structural stall:** id_is_mc && mc_busy && !mc_done.
- **WAW stall:** id_we && id_rd≠0 && pend[id_rd] && !(mc_done && mc_rd==id_rd).
- **id_fire gating:** id_fire is ignored while stall=1; the upstream pipeline guarantees id_fire implies !stall.
- **Scoreboard update at posedge:**
  - Clear pend[mc_rd] on mc_done.
  - Set pend[id_rd] on id_fire && id_is_mc && id_we && id_rd≠0.
  - Set wins if both hit the same register.
  - pend[0] is always 0.
- **mc_busy:**
  - Set on id_fire && id_is_mc.
  - Cleared on mc_done unless a new multi-cycle op fires in the same cycle, in which case it stays 1.
- **stall_cnt:** increments each cycle stall=1 and saturates at 0xFFFF_FFFF.
- **Register 0:** never matches, never stalls, never set in the scoreboard.

## Timing
- fwd_sel and stall are combinational from the inputs and current state, with zero latency; they are valid in the same cycle the ID inputs are valid.
- pend, mc_busy and stall_cnt are registered with one-cycle update latency.
- A result writes back from the multi-cycle unit with mc_done at cycle t:
  - a dependent instruction in ID at t is unstalled at t and forwarded with sel=NSRC+1;
  - at t+1 its pend bit is 0.
- Reset (asynchronous, any time, including mid multi-cycle op): pend=0, mc_busy=0, stall_cnt=0.
- Outputs during reset: fwd_sel and stall follow the combinational rules with pend=0. An mc_done arriving after reset is harmless because clearing an already-clear bit does nothing.
- Flush needs no input: squashed stages arrive with stg_we=0. A multi-cycle op that was already issued still completes and clears its bit.

## Structure
- Package fwd_pkg holds:
  - SEL_RF=0;
  - function sel_stage(k)=k+1;
  - function sel_mc(nsrc)=nsrc+1;
  - the stall-cause enum {NONE, LOADUSE, MCPEND, STRUCT, WAW} for debug.
- Sub-module fwd_port_match: one port's priority encoder plus its load-use/pending hazard bit. It is instantiated NRP times with a generate loop.
- Scoreboard, mc_busy and the counter live in the top module.

## Test plan
- Defaults, with stg_we=3'b011, stg_rd = EX:x5, MEM:x5, stg_rdy=3'b111, and id_rs port0=x5 used -> fwd_sel[0]=1 (EX wins), stall=0.
- Load-use: EX stg_rd=x7, stg_rdy[0]=0, port1 reads x7 -> stall=1 for one cycle. The next cycle, with the load in MEM and rdy=1, gives fwd_sel[1]=2 and stall=0; stall_cnt=1.
- Multi-cycle: DIV to x9 fires, so pend[9]=1 and mc_busy=1. A reader of x9 stalls. mc_done with mc_rd=x9 gives fwd_sel=4 and stall=0 that cycle, and pend[9]=0 the next cycle.
- Structural and WAW: while mc_busy, an MUL in ID gives stall=1. An ALU op writing pending x9 gives stall=1. Back-to-back DIV on the mc_done cycle fires, and mc_busy stays 1.
- x0 and reset: id_rs=x0 with a matching stage gives fwd_sel=0 and stall=0. Dropping rstn low mid-DIV clears pend, mc_busy and stall_cnt asynchronously.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the decode-stage forwarding and interlock unit.
package fwd_pkg;

  // Select code meaning "read the register file, no bypass".
  localparam int SEL_RF = 0;

  // Reason the decode stage is held, used for debug visibility.
  typedef enum logic [2:0] {
    NONE,
    LOADUSE,
    MCPEND,
    STRUCT,
    WAW
  } stall_cause_e;

  // Select code for bypass stage k (0 = youngest).
  function automatic int sel_stage(input int k);
    return k + 1;
  endfunction

  // Select code for the multi-cycle unit's writeback result.
  function automatic int sel_mc(input int nsrc);
    return nsrc + 1;
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// One read port: newest-producer priority encoder plus its data hazard bits.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int NSRC  = 3,
  parameter int NREG  = 32,
  parameter int RW    = $clog2(NREG),
  parameter int SEL_W = $clog2(NSRC + 2)
) (
  input  logic [RW-1:0]      i_rs,
  input  logic               i_used,
  input  logic [NSRC*RW-1:0] i_stg_rd,
  input  logic [NSRC-1:0]    i_stg_we,
  input  logic [NSRC-1:0]    i_stg_rdy,
  input  logic               i_mc_done,
  input  logic [RW-1:0]      i_mc_rd,
  input  logic [NREG-1:0]    i_pend,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_loaduse,
  output logic               o_mcpend
);

  logic w_mc_hit;
  logic w_found;

  // The multi-cycle unit is writing this port's register right now.
  assign w_mc_hit = i_mc_done && (i_mc_rd == i_rs);

  // Youngest matching stage wins; the multi-cycle result is the last resort before the regfile.
  always_comb begin
    o_sel     = SEL_W'(SEL_RF);
    o_loaduse = 1'b0;
    o_mcpend  = 1'b0;
    w_found   = 1'b0;
    if (i_used && (i_rs != '0)) begin
      for (int k = 0; k < NSRC; k++) begin
        if (!w_found && i_stg_we[k] && (i_stg_rd[k*RW +: RW] == i_rs)) begin
          w_found   = 1'b1;
          o_sel     = SEL_W'(sel_stage(k));
          o_loaduse = !i_stg_rdy[k];
        end
      end
      if (!w_found && w_mc_hit) begin
        o_sel = SEL_W'(sel_mc(NSRC));
      end
      o_mcpend = i_pend[i_rs] && !w_mc_hit;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding select, interlock and multi-cycle register scoreboard.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NRP   = 3,
  parameter int NSRC  = 3,
  parameter int NREG  = 32,
  parameter int RW    = $clog2(NREG),
  parameter int SEL_W = $clog2(NSRC + 2)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NRP*RW-1:0]    id_rs,
  input  logic [NRP-1:0]       id_rs_used,
  input  logic [RW-1:0]        id_rd,
  input  logic                 id_we,
  input  logic                 id_is_mc,
  input  logic                 id_fire,
  input  logic [NSRC*RW-1:0]   stg_rd,
  input  logic [NSRC-1:0]      stg_we,
  input  logic [NSRC-1:0]      stg_rdy,
  input  logic                 mc_done,
  input  logic [RW-1:0]        mc_rd,
  output logic [NRP*SEL_W-1:0] fwd_sel,
  output logic                 stall,
  output logic                 mc_busy,
  output logic [NREG-1:0]      pend,
  output logic [31:0]          stall_cnt
);

  logic [NREG-1:0] r_pend;
  logic            r_mc_busy;
  logic [31:0]     r_stall_cnt;

  logic [NRP-1:0]  w_loaduse;
  logic [NRP-1:0]  w_mcpend;
  logic            w_struct;
  logic            w_waw;
  logic            w_fire;
  logic            w_mc_set;
  logic [NREG-1:0] w_pend_nxt;
  stall_cause_e    w_cause;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_port_match #(
      .NSRC  (NSRC),
      .NREG  (NREG),
      .RW    (RW),
      .SEL_W (SEL_W)
    ) u_match (
      .i_rs      (id_rs[p*RW +: RW]),
      .i_used    (id_rs_used[p]),
      .i_stg_rd  (stg_rd),
      .i_stg_we  (stg_we),
      .i_stg_rdy (stg_rdy),
      .i_mc_done (mc_done),
      .i_mc_rd   (mc_rd),
      .i_pend    (r_pend),
      .o_sel     (fwd_sel[p*SEL_W +: SEL_W]),
      .o_loaduse (w_loaduse[p]),
      .o_mcpend  (w_mcpend[p])
    );
  end

  // A second multi-cycle op cannot start unless the current one finishes this cycle.
  assign w_struct = id_is_mc && r_mc_busy && !mc_done;
  // Writing a register still owed by the multi-cycle unit would be overtaken by its late result.
  assign w_waw    = id_we && (id_rd != '0) && r_pend[id_rd] && !(mc_done && (mc_rd == id_rd));
  // A stalled instruction never advances, whatever id_fire says.
  assign w_fire   = id_fire && !stall;
  assign w_mc_set = w_fire && id_is_mc && id_we && (id_rd != '0);

  // Pick one stall cause in priority order; stall is simply "any cause present".
  always_comb begin
    w_cause = NONE;
    if (|w_loaduse)    w_cause = LOADUSE;
    else if (|w_mcpend) w_cause = MCPEND;
    else if (w_struct)  w_cause = STRUCT;
    else if (w_waw)     w_cause = WAW;
  end

  assign stall = (w_cause != NONE);

  // Next scoreboard: retire the writeback first so a same-register issue wins; x0 never pends.
  always_comb begin
    w_pend_nxt = r_pend;
    if (mc_done)  w_pend_nxt[mc_rd] = 1'b0;
    if (w_mc_set) w_pend_nxt[id_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // Scoreboard, multi-cycle occupancy and saturating stall counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend      <= '0;
      r_mc_busy   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_fire && id_is_mc) r_mc_busy <= 1'b1;
      else if (mc_done)       r_mc_busy <= 1'b0;
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign pend      = r_pend;
  assign mc_busy   = r_mc_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
